// File: rtl/car_sensor_conditioner.sv
// Car-detector front end: synchronises, debounces and latches North/East arrivals into requests.
// Optional stuck-detector masking is built when SENSOR_STUCK_DET_EN is defined.
module car_sensor_conditioner #(
  parameter int TICK_DIV    = 1000,
  parameter int DEB_COUNT   = 8,
  parameter int STUCK_TICKS = 4096
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic SensN_raw,
  input  logic SensE_raw,
  input  logic ServedN,
  input  logic ServedE,
  output logic InN,
  output logic InE,
  output logic PresN,
  output logic PresE,
  output logic FaultN,
  output logic FaultE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEB_COUNT > 1) ? $clog2(DEB_COUNT) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_COUNT - 1);

  logic [PW-1:0] r_pre;
  logic          w_tick;
  logic [1:0]    w_raw;
  logic [1:0]    w_served;
  logic [1:0]    w_pres;
  logic [1:0]    w_in;
  logic [1:0]    w_fault;

  assign w_tick   = (r_pre == PRE_MAX);
  assign w_raw    = {SensE_raw, SensN_raw};
  assign w_served = {ServedE, ServedN};

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)    r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + 1'b1;
  end

  // Channel 0 is North, channel 1 is East; both are identical and independent.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic          r_sync1, r_sync2;
    logic          r_pres, r_pres_d, r_lat, r_in;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync1  <= 1'b0;
        r_sync2  <= 1'b0;
        r_pres   <= 1'b0;
        r_cnt    <= '0;
        r_pres_d <= 1'b0;
        r_lat    <= 1'b0;
        r_in     <= 1'b0;
      end else begin
        r_sync1  <= w_raw[gi];
        r_sync2  <= r_sync1;
        r_pres_d <= r_pres;
        if (w_tick) begin
          if (r_sync2 == r_pres) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_pres <= r_sync2;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Arrival edge beats the served clear so a car arriving on green is not lost.
        if (r_pres && !r_pres_d) r_lat <= 1'b1;
        else if (w_served[gi])   r_lat <= 1'b0;
        r_in <= (r_pres & ~w_fault[gi]) | r_lat;
      end
    end

`ifdef SENSOR_STUCK_DET_EN
    localparam int SW = (STUCK_TICKS > 1) ? $clog2(STUCK_TICKS) : 1;
    localparam logic [SW-1:0] STK_MAX = SW'(STUCK_TICKS - 1);
    logic [SW-1:0] r_stk;
    logic          r_fault;

    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
        r_stk   <= '0;
        r_fault <= 1'b0;
      end else if (!r_pres) begin
        r_stk <= '0;
      end else if (w_tick) begin
        if (r_stk == STK_MAX) r_fault <= 1'b1;
        else                  r_stk   <= r_stk + 1'b1;
      end
    end
    assign w_fault[gi] = r_fault;
`else
    assign w_fault[gi] = 1'b0 & (STUCK_TICKS == 0);
`endif

    assign w_pres[gi] = r_pres;
    assign w_in[gi]   = r_in;
  end

  assign PresN  = w_pres[0];
  assign PresE  = w_pres[1];
  assign InN    = w_in[0];
  assign InE    = w_in[1];
  assign FaultN = w_fault[0];
  assign FaultE = w_fault[1];

endmodule

// File: doc/car_sensor_conditioner.md
Name: car_sensor_conditioner

Overview:
Front-end conditioning stage for the intersection controller. It takes raw, asynchronous, bouncy car-detector inputs for the North and East approaches and produces clean, synchronous request levels. Those levels drive the controller's InN/InE inputs directly. Each arrival is latched until the controller reports that the approach has been served, so short detector pulses are never lost.

Parameters:
TICK_DIV, 1000, Clk cycles per debounce sample tick (>=1; 1 = sample every cycle)
DEB_COUNT, 8, consecutive differing ticks required to accept a new detector level (>=1)
STUCK_TICKS, 4096, ticks of continuous presence before a channel is declared stuck (optional feature only)

Ports:
Clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
SensN_raw  in  1  raw North detector, async, active-high
SensE_raw  in  1  raw East detector, async, active-high
ServedN  in  1  high while North has green (controller OutN == 3'b110)
ServedE  in  1  high while East has green (controller OutE == 3'b110)
InN  out  1  conditioned North request to controller
InE  out  1  conditioned East request to controller
PresN  out  1  debounced North presence
PresE  out  1  debounced East presence
FaultN  out  1  North detector stuck flag (0 when feature compiled out)
FaultE  out  1  East detector stuck flag (0 when feature compiled out)

Behaviour:
- Reset (async, active-low) clears all state immediately, mid-operation included:
  - all outputs 0; sync flops 0; prescaler 0; debounce counters 0; latches 0.
- Synchronizer: 2-flop chain per raw input. Only the second flop's output (syncX) is used downstream.
- Prescaler:
  - Counter 0..TICK_DIV-1, wraps to 0.
  - tick is a 1-cycle pulse in the cycle the counter equals TICK_DIV-1.
  - TICK_DIV=1 gives tick=1 every cycle.
  - Width: $clog2(TICK_DIV), minimum 1.
- Debounce, per channel, evaluated only on tick; between ticks state holds:
  - syncX == PresX: cntX <= 0.
  - syncX != PresX and cntX == DEB_COUNT-1: PresX <= syncX, cntX <= 0.
  - syncX != PresX otherwise: cntX <= cntX+1.
  - A glitch shorter than DEB_COUNT ticks never changes PresX.
  - Latency from a stable raw edge is 2 Clk + DEB_COUNT ticks, plus up to one tick of phase.
- Request latch, per channel:
  - presX_d is PresX delayed by one Clk.
  - Set in the cycle after a PresX 0->1 edge, i.e. when PresX & ~presX_d.
  - Cleared in any cycle where ServedX=1.
  - Set and clear in the same cycle: set wins, so a car arriving during green still produces a request.
- Output: InX = PresX | latX, registered (one Clk after its sources).
- Channels are fully independent. Simultaneous N and E events are both honoured. The controller arbitrates.
- Counter widths:
  - cntX: $clog2(DEB_COUNT), minimum 1.
  - Counters never exceed their terminal value and carry no overflow state.

Optional Feature:
SENSOR_STUCK_DET_EN
- Defined:
  - Per channel, a stuck counter counts ticks while PresX=1 and clears whenever PresX=0.
  - On reaching STUCK_TICKS-1 with PresX still 1, FaultX is set. FaultX is sticky until reset.
  - While FaultX=1, InX = latX only; the PresX term is masked. Since no new presence edge can occur, the faulty approach stops holding the controller, preventing starvation of the other approach.
  - FaultX clears only on reset.
- Undefined: no stuck counters are built; FaultN/FaultE are tied 0; InX = PresX | latX always.

Test Plan (TICK_DIV=4, DEB_COUNT=3, STUCK_TICKS=16):
- Reset: hold reset_n=0 with SensN_raw=SensE_raw=1 -> all outputs 0. Release -> PresN=PresE=1 after 2 Clk + 3 ticks (<=14 Clk); InN/InE follow 1 Clk later.
- Glitch reject: SensN_raw pulse of 8 Clk (2 ticks) -> PresN and InN stay 0.
- Latch: SensE_raw high 20 Clk then low, ServedE=0 -> PresE returns to 0 but InE stays 1. Pulse ServedE for 1 Clk -> InE=0 one Clk later.
- Set-vs-clear race: force a PresN rising edge in the same cycle as ServedN=1 -> latN=1 and InN remains 1 after ServedN drops.
- Concurrency: SensN_raw and SensE_raw rise on the same Clk -> InN and InE assert on the same cycle. Assert reset_n=0 mid-debounce -> counters and outputs 0 immediately.
- SENSOR_STUCK_DET_EN defined: hold SensN_raw=1 for 100 Clk -> FaultN=1 after 16 ticks of presence; once latN is cleared by ServedN, InN=0 despite PresN=1. With the macro undefined, the same stimulus gives FaultN=0 and InN=1.
